// File: rtl/fifo_pkg.sv
// Shared asynchronous-FIFO definitions: default depth and Gray/binary conversion
// helpers used by both the read-side empty checker and the write-side full checker.
package fifo_pkg;

  localparam int DEFAULT_ADDR_SIZE = 4;
  localparam int MAX_PTR_W         = 32;

  // Callers zero-extend narrower pointers; zero upper bits leave the result unchanged.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_PTR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchroniser with asynchronous active-high reset.
// The input goes straight into the first flop with no logic in front of it.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/empty_checker.sv
// Read-side pointer, empty flag, fill level and underflow tracking for the async FIFO.
// Optional build macro ALMOST_EMPTY_EN enables the registered almost-empty flag.
module empty_checker
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int AE_THRESH = 2
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_en,
  input  logic [ADDR_SIZE:0]   w_ptr_gray,
  output logic [ADDR_SIZE-1:0] r_addr,
  output logic [ADDR_SIZE:0]   r_ptr_gray,
  output logic                 r_empty,
  output logic [ADDR_SIZE:0]   r_level,
  output logic                 r_almost_empty,
  output logic                 r_underflow
);

  localparam int PW = ADDR_SIZE + 1;

  if (AE_THRESH < 0 || AE_THRESH > (1 << ADDR_SIZE)) begin : g_bad_thresh
    $error("empty_checker: AE_THRESH out of range 0..2**ADDR_SIZE");
  end

  logic [PW-1:0] wq2;
  logic [PW-1:0] wq2_bin;
  logic [PW-1:0] r_ptr_bin;
  logic [PW-1:0] ptr_bin_next;
  logic [PW-1:0] ptr_gray_next;
  logic [PW-1:0] level_next;
  logic          rd_ok;

  sync_2ff #(.WIDTH(PW)) u_wptr_sync (
    .clk (r_clk),
    .rst (r_rst),
    .d   (w_ptr_gray),
    .q   (wq2)
  );

  // Handshake: r_en is the request, ~r_empty is the ready; a read is taken only
  // on an edge where both are high, otherwise the pointer holds.
  always_comb begin
    rd_ok         = r_en & ~r_empty;
    ptr_bin_next  = r_ptr_bin + PW'(rd_ok);
    ptr_gray_next = PW'(bin2gray(MAX_PTR_W'(ptr_bin_next)));
    wq2_bin       = PW'(gray2bin(MAX_PTR_W'(wq2)));
    level_next    = wq2_bin - ptr_bin_next;
  end

  assign r_addr = r_ptr_bin[ADDR_SIZE-1:0];

  // Empty is a plain full-width Gray compare; only the full side inverts MSBs.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_ptr_bin   <= '0;
      r_ptr_gray  <= '0;
      r_empty     <= 1'b1;
      r_level     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_ptr_bin   <= ptr_bin_next;
      r_ptr_gray  <= ptr_gray_next;
      r_empty     <= (ptr_gray_next == wq2);
      r_level     <= level_next;
      r_underflow <= r_underflow | (r_en & r_empty);
    end
  end

`ifdef ALMOST_EMPTY_EN
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_empty <= (level_next <= PW'(AE_THRESH));
    end
  end
`else
  assign r_almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_empty_checker.sv
// Directed bench for empty_checker (ADDR_SIZE=4): reset, sync latency, reads,
// pointer wrap, full view and asynchronous reset in the middle of traffic.
module tb_empty_checker;

  logic       r_clk;
  logic       r_rst;
  logic       r_en;
  logic [4:0] w_ptr_gray;
  logic [3:0] r_addr;
  logic [4:0] r_ptr_gray;
  logic       r_empty;
  logic [4:0] r_level;
  logic       r_almost_empty;
  logic       r_underflow;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_ptr = 0;
  int exp_w   = 0;

  empty_checker dut (
    .r_clk          (r_clk),
    .r_rst          (r_rst),
    .r_en           (r_en),
    .w_ptr_gray     (w_ptr_gray),
    .r_addr         (r_addr),
    .r_ptr_gray     (r_ptr_gray),
    .r_empty        (r_empty),
    .r_level        (r_level),
    .r_almost_empty (r_almost_empty),
    .r_underflow    (r_underflow)
  );

  // clock / reset
  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  function automatic logic ae_of(input int lvl);
`ifdef ALMOST_EMPTY_EN
    return (lvl <= 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, r_empty, 1);
    chk({tag, "_addr"}, r_addr, 0);
    chk({tag, "_gray"}, r_ptr_gray, 0);
    chk({tag, "_level"}, r_level, 0);
    chk({tag, "_ae"}, r_almost_empty, ae_of(0));
    chk({tag, "_uflow"}, r_underflow, 0);
  endtask

  task automatic sync_w(input int bin, input logic [4:0] gray);
    w_ptr_gray = gray;
    exp_w = bin;
    repeat (3) tick();
    chk("sync_level", r_level, (exp_w - exp_ptr + 32) % 32);
    chk("sync_empty", r_empty, exp_w == exp_ptr);
    chk("sync_ae", r_almost_empty, ae_of((exp_w - exp_ptr + 32) % 32));
  endtask

  task automatic read_n(input int n);
    r_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("rd_addr", r_addr, exp_ptr % 16);
      tick();
      exp_ptr = (exp_ptr + 1) % 32;
      chk("rd_gray", r_ptr_gray, g(exp_ptr));
      chk("rd_level", r_level, (exp_w - exp_ptr + 32) % 32);
      chk("rd_empty", r_empty, exp_w == exp_ptr);
    end
    r_en = 1'b0;
  endtask

  int step_addr[5]  = '{0, 1, 2, 3, 4};
  int step_gray[5]  = '{1, 3, 2, 6, 7};
  int step_level[5] = '{4, 3, 2, 1, 0};
  int wrap_addr[4]  = '{14, 15, 0, 1};
  int wrap_gray[4]  = '{16, 0, 1, 3};
  int wrap_level[4] = '{3, 2, 1, 0};

  initial begin
    r_rst = 1'b1;
    r_en = 1'b0;
    w_ptr_gray = 5'd0;
    repeat (2) tick();
    chk_reset_state("reset");

    // idle reads while empty: underflow sets after the first edge, nothing moves
    r_rst = 1'b0;
    r_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_empty", r_empty, 1);
      chk("idle_addr", r_addr, 0);
      chk("idle_gray", r_ptr_gray, 0);
      chk("idle_level", r_level, 0);
      chk("idle_uflow", r_underflow, 1);
    end

    // write pointer 0 -> 1: empty deasserts on the third edge
    r_en = 1'b0;
    w_ptr_gray = 5'd1;
    exp_w = 1;
    tick();
    chk("lat_e1_empty", r_empty, 1);
    tick();
    chk("lat_e2_empty", r_empty, 1);
    tick();
    chk("lat_e3_empty", r_empty, 0);
    chk("lat_e3_level", r_level, 1);
    chk("lat_e3_ae", r_almost_empty, ae_of(1));

    // five entries, five back-to-back reads
    sync_w(5, 5'd7);
    r_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("burst_addr", r_addr, step_addr[i]);
      tick();
      chk("burst_gray", r_ptr_gray, step_gray[i]);
      chk("burst_level", r_level, step_level[i]);
      chk("burst_empty", r_empty, i == 4);
    end
    r_en = 1'b0;
    exp_ptr = 5;
    chk("burst_uflow_sticky", r_underflow, 1);

    // walk the read pointer to 30, then read across the wrap
    sync_w(20, 5'd30);
    read_n(15);
    sync_w(30, 5'd17);
    read_n(10);
    sync_w(2, 5'd3);
    r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", r_addr, wrap_addr[i]);
      tick();
      chk("wrap_gray", r_ptr_gray, wrap_gray[i]);
      chk("wrap_level", r_level, wrap_level[i]);
      chk("wrap_empty", r_empty, i == 3);
    end
    r_en = 1'b0;
    exp_ptr = 2;

    // full view from a fresh reset: write pointer 16 ahead
    r_rst = 1'b1;
    #1;
    chk_reset_state("reset2");
    w_ptr_gray = 5'd24;
    exp_w = 16;
    exp_ptr = 0;
    tick();
    r_rst = 1'b0;
    tick();
    chk("full_e1_level", r_level, 0);
    tick();
    chk("full_e2_empty", r_empty, 1);
    tick();
    chk("full_level", r_level, 16);
    chk("full_empty", r_empty, 0);
    chk("full_ae", r_almost_empty, ae_of(16));

    // drain to level 6, then reset asynchronously mid-cycle with a read pending
    read_n(10);
    chk("pre_rst_level", r_level, 6);
    r_en = 1'b1;
    #2;
    r_rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    r_en = 1'b0;
    repeat (2) tick();
    r_rst = 1'b0;
    exp_ptr = 0;
    tick();
    chk("rec_e1_empty", r_empty, 1);
    tick();
    chk("rec_e2_empty", r_empty, 1);
    tick();
    chk("rec_e3_empty", r_empty, 0);
    chk("rec_level", r_level, 16);
    chk("rec_addr", r_addr, 0);
    chk("rec_uflow", r_underflow, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
